// File: rtl/cpu_defs.sv
// Shared CPU definitions: default datapath widths, memory depth and the
// fetch state encoding used by the fetch stage.
package cpu_defs;

  localparam int DEFAULT_ADDR_W = 4;
  localparam int DEFAULT_DATA_W = 8;
  localparam int RAM_DEPTH      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_counter.sv
// Loadable program counter. Load wins over increment, and the wrap pulse
// is raised only by an increment that rolls the counter over to zero.
module pc_counter #(
  parameter int ADDR_W = cpu_defs::DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] count,
  output logic              wrap
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        count <= load_val;
      end else if (inc) begin
        count <= count + 1'b1;
        wrap  <= (count == {ADDR_W{1'b1}});
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, ram read sequencing with a programmable wait,
// instruction register and a valid/ready handoff to decode.
module fetch_unit
  import cpu_defs::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int READ_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              ir_ready,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_read_en,
  output logic              ram_write_en,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              wrapped
);

  localparam int CNT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(READ_WAIT - 1);

  fetch_state_e     state, state_next;
  logic [CNT_W-1:0] wait_cnt;

  logic pc_inc;
  logic pc_load;
  logic ir_load;
  logic valid_clr;
  logic cnt_load;
  logic cnt_dec;

  pc_counter #(.ADDR_W(ADDR_W)) u_pc (
    .clk      (clk),
    .reset    (reset),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (jump_addr),
    .count    (pc),
    .wrap     (wrapped)
  );

  assign ram_address  = pc;
  assign ram_read_en  = (state == READ);
  assign ram_write_en = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    pc_inc     = 1'b0;
    pc_load    = jump_en;
    ir_load    = 1'b0;
    valid_clr  = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    unique case (state)
      IDLE: begin
        if (run) begin
          state_next = READ;
          cnt_load   = 1'b1;
        end
      end
      READ: begin
        if (jump_en) begin
          // Abandon the in-flight fetch; restart at the new PC if still running.
          state_next = run ? READ : IDLE;
          cnt_load   = 1'b1;
        end else if (wait_cnt == '0) begin
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          state_next = HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      HOLD: begin
        if (ir_ready) begin
          valid_clr = 1'b1;
          if (run) begin
            state_next = READ;
            cnt_load   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir       <= '0;
      ir_valid <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (ir_load) begin
        ir       <= ram_data_out;
        ir_valid <= 1'b1;
      end else if (valid_clr) begin
        ir_valid <= 1'b0;
      end

      if (cnt_load)     wait_cnt <= CNT_RELOAD;
      else if (cnt_dec) wait_cnt <= wait_cnt - 1'b1;
    end
  end

endmodule
